// File: rtl/arbiter_mux_rr_pkg.sv
// Shared constants, FSM encoding and index-width helper for the arbitrated
// multiplexer and its priority encoder.
package arbiter_mux_rr_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Width of a channel index; never less than one bit.
   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arbiter_mux_rr_priority_encoder.sv
// Combinational request picker: first requester at or above the pointer
// (wrapping) in round-robin mode, lowest requester in fixed mode.
module rr_priority_encoder
   import arbiter_mux_rr_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          mode,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any_req
);

   always_comb begin
      int   start;
      int   j;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      start = mode ? int'(ptr) : 0;
      j     = 0;
      for (int off = 0; off < N; off++) begin
         j = start + off;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/arbiter_mux_rr.sv
// N-channel arbitrated mux: pops one non-empty show-ahead FIFO per cycle,
// holding a grant for up to BURST pops, and registers the word downstream.
module arbiter_mux_rr
   import arbiter_mux_rr_pkg::*;
#(
   parameter int N     = 4,
   parameter int W     = 10,
   parameter int BURST = 1,
   parameter int MODE  = MODE_RR
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N*W-1:0]        fifo_data,
   input  logic [N-1:0]          fifo_empty,
   input  logic                  dest_full,
   output logic [N-1:0]          fifo_pop,
   output logic [W-1:0]          data_out,
   output logic                  valid_out,
   output logic [idx_w(N)-1:0]   grant_idx
);

   localparam int IW = idx_w(N);
   localparam int BW = $clog2(BURST + 1);

   state_t         state_reg, state_next;
   logic [IW-1:0]  ptr_reg, ptr_next;
   logic [BW-1:0]  cnt_reg, cnt_next;
   logic [N-1:0]   req;
   logic [N-1:0]   pop_c;
   logic           pop_en;
   logic [IW-1:0]  win_idx;
   logic           owner_ok;
   logic [N-1:0]   enc_grant;
   logic [IW-1:0]  enc_idx;
   logic           enc_any;
   logic [W-1:0]   words [N];

   assign req = ~fifo_empty;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_words
         assign words[gi] = fifo_data[gi*W +: W];
      end
   endgenerate

   rr_priority_encoder #(
      .N  (N),
      .IW (IW)
   ) u_enc (
      .req     (req),
      .ptr     (ptr_reg),
      .mode    (MODE == MODE_RR),
      .grant   (enc_grant),
      .idx     (enc_idx),
      .any_req (enc_any)
   );

   // Owner keeps the grant until its burst is spent or it runs dry; a stall
   // freezes everything, including the burst count.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      pop_c      = '0;
      pop_en     = 1'b0;
      win_idx    = grant_idx;
      owner_ok   = (state_reg == HOLD) && req[grant_idx] && (cnt_reg < BW'(BURST));
      if (!dest_full) begin
         if (owner_ok) begin
            pop_en           = 1'b1;
            pop_c[grant_idx] = 1'b1;
            cnt_next         = cnt_reg + 1'b1;
         end else if (enc_any) begin
            pop_en     = 1'b1;
            pop_c      = enc_grant;
            win_idx    = enc_idx;
            cnt_next   = BW'(1);
            state_next = HOLD;
            if (MODE == MODE_RR)
               ptr_next = (enc_idx == IW'(N-1)) ? '0 : enc_idx + 1'b1;
         end else begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      end
   end

   // The encoder sees requests even while reset is low, so gate the pop here.
   assign fifo_pop = reset ? pop_c : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         grant_idx <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         if (pop_en) begin
            data_out  <= words[win_idx];
            grant_idx <= win_idx;
            valid_out <= 1'b1;
         end else begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arbiter_mux_rr.sv
// Directed bench: three instances (round-robin, fixed priority, burst of 3)
// driven from a per-cycle vector table plus hand-written reset sequences.
module tb_arbiter_mux_rr;

   localparam logic [9:0] H0 = 10'h0A1;
   localparam logic [9:0] H1 = 10'h0B2;
   localparam logic [9:0] H2 = 10'h0C3;
   localparam logic [9:0] H3 = 10'h0D4;

   logic        clk = 1'b0;
   logic        reset;
   logic [39:0] heads;
   logic [3:0]  empty_a [3];
   logic        full_a  [3];
   logic [3:0]  pop_a   [3];
   logic [9:0]  dout_a  [3];
   logic        valid_a [3];
   logic [1:0]  gidx_a  [3];

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         k;
      logic [3:0] empty;
      logic       full;
      logic [3:0] pop;
      logic       valid;
      logic [9:0] data;
      logic [1:0] gidx;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   assign heads = {H3, H2, H1, H0};

   arbiter_mux_rr #(.N(4), .W(10), .BURST(1), .MODE(1)) dut_rr (
      .clk(clk), .reset(reset), .fifo_data(heads), .fifo_empty(empty_a[0]),
      .dest_full(full_a[0]), .fifo_pop(pop_a[0]), .data_out(dout_a[0]),
      .valid_out(valid_a[0]), .grant_idx(gidx_a[0]));

   arbiter_mux_rr #(.N(4), .W(10), .BURST(1), .MODE(0)) dut_fp (
      .clk(clk), .reset(reset), .fifo_data(heads), .fifo_empty(empty_a[1]),
      .dest_full(full_a[1]), .fifo_pop(pop_a[1]), .data_out(dout_a[1]),
      .valid_out(valid_a[1]), .grant_idx(gidx_a[1]));

   arbiter_mux_rr #(.N(4), .W(10), .BURST(3), .MODE(1)) dut_bu (
      .clk(clk), .reset(reset), .fifo_data(heads), .fifo_empty(empty_a[2]),
      .dest_full(full_a[2]), .fifo_pop(pop_a[2]), .data_out(dout_a[2]),
      .valid_out(valid_a[2]), .grant_idx(gidx_a[2]));

   task automatic add(input int k, input logic [3:0] empty, input logic full,
                      input logic [3:0] pop, input logic valid,
                      input logic [9:0] data, input logic [1:0] gidx);
      vec_t v;
      v.k = k; v.empty = empty; v.full = full; v.pop = pop;
      v.valid = valid; v.data = data; v.gidx = gidx;
      vecs.push_back(v);
   endtask

   task automatic chk_pop(input string name, input int k, input logic [3:0] want);
      tests++;
      if (pop_a[k] !== want) begin
         fails++;
         $display("FAIL %s dut%0d fifo_pop: got %b want %b", name, k, pop_a[k], want);
      end else
         $display("[TB] ok   %s dut%0d fifo_pop=%b", name, k, pop_a[k]);
   endtask

   task automatic chk_out(input string name, input int k, input logic valid,
                          input logic [9:0] data, input logic [1:0] gidx);
      tests++;
      if (valid_a[k] !== valid || dout_a[k] !== data || gidx_a[k] !== gidx) begin
         fails++;
         $display("FAIL %s dut%0d outputs: got valid=%b data=%h gidx=%0d want valid=%b data=%h gidx=%0d",
                  name, k, valid_a[k], dout_a[k], gidx_a[k], valid, data, gidx);
      end else
         $display("[TB] ok   %s dut%0d valid=%b data=%h gidx=%0d",
                  name, k, valid_a[k], dout_a[k], gidx_a[k]);
   endtask

   initial begin
      // Round-robin, burst 1: rotation 0..3, wrap from pointer 3, drain, stall.
      for (int r = 0; r < 2; r++) begin
         add(0, 4'b0000, 1'b0, 4'b0001, 1'b1, H0, 2'd0);
         add(0, 4'b0000, 1'b0, 4'b0010, 1'b1, H1, 2'd1);
         add(0, 4'b0000, 1'b0, 4'b0100, 1'b1, H2, 2'd2);
         if (r == 0) add(0, 4'b0000, 1'b0, 4'b1000, 1'b1, H3, 2'd3);
      end
      add(0, 4'b1110, 1'b0, 4'b0001, 1'b1, H0, 2'd0);
      add(0, 4'b1111, 1'b0, 4'b0000, 1'b0, H0, 2'd0);
      add(0, 4'b0000, 1'b1, 4'b0000, 1'b0, H0, 2'd0);
      // Fixed priority: channel 1 starves channel 3 until it empties.
      for (int r = 0; r < 3; r++)
         add(1, 4'b0101, 1'b0, 4'b0010, 1'b1, H1, 2'd1);
      add(1, 4'b0111, 1'b0, 4'b1000, 1'b1, H3, 2'd3);
      add(1, 4'b0101, 1'b0, 4'b0010, 1'b1, H1, 2'd1);
      add(1, 4'b1111, 1'b0, 4'b0000, 1'b0, H1, 2'd1);
      // Burst of 3: 0,0,0,2,2,2,0 then early empty, stall, resume.
      for (int r = 0; r < 3; r++) add(2, 4'b1010, 1'b0, 4'b0001, 1'b1, H0, 2'd0);
      for (int r = 0; r < 3; r++) add(2, 4'b1010, 1'b0, 4'b0100, 1'b1, H2, 2'd2);
      for (int r = 0; r < 2; r++) add(2, 4'b1010, 1'b0, 4'b0001, 1'b1, H0, 2'd0);
      add(2, 4'b1011, 1'b0, 4'b0100, 1'b1, H2, 2'd2);
      add(2, 4'b1010, 1'b0, 4'b0100, 1'b1, H2, 2'd2);
      for (int r = 0; r < 4; r++) add(2, 4'b1010, 1'b1, 4'b0000, 1'b0, H2, 2'd2);
      add(2, 4'b1010, 1'b0, 4'b0100, 1'b1, H2, 2'd2);
      add(2, 4'b1010, 1'b0, 4'b0001, 1'b1, H0, 2'd0);

      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         empty_a[k] = 4'b0000;
         full_a[k]  = 1'b0;
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            chk_pop("reset", k, 4'b0000);
            chk_out("reset", k, 1'b0, 10'h000, 2'd0);
         end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) empty_a[k] = 4'b1111;
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         string nm;
         v  = vecs[i];
         nm = $sformatf("vec%0d", i);
         @(negedge clk);
         empty_a[v.k] = v.empty;
         full_a[v.k]  = v.full;
         #1;
         chk_pop(nm, v.k, v.pop);
         @(posedge clk); #1;
         chk_out(nm, v.k, v.valid, v.data, v.gidx);
      end

      // Reset mid-burst on the burst instance, pointer currently at 1.
      @(negedge clk);
      empty_a[2] = 4'b1010;
      full_a[2]  = 1'b0;
      #1;
      chk_pop("preburst", 2, 4'b0001);
      reset = 1'b0;
      #1;
      chk_pop("midrst", 2, 4'b0000);
      chk_out("midrst", 2, 1'b0, 10'h000, 2'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_pop("postrst", 2, 4'b0001);
      @(posedge clk); #1;
      chk_out("postrst", 2, 1'b1, H0, 2'd0);
      @(negedge clk); #1;
      chk_pop("postrst_hold", 2, 4'b0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
